// File: rtl/dds_wave_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_wave_gen : DDS phase accumulator with sine/square/triangle/sawtooth   |
// |                lookup and amplitude scaling about midscale for the DAC.  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module dds_wave_gen #(
    parameter int PHASE_W = 32
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_amp,
    output logic [7:0]         data_out,
    output logic               sync_out
);

    localparam logic [7:0] MIDSCALE    = 8'd128;
    localparam logic [7:0] AMP_FULL    = 8'd255;
    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

    // Active and shadow configuration
    logic [PHASE_W-1:0] ftw_a_q, ftw_a_d;
    logic [PHASE_W-1:0] ftw_s_q, ftw_s_d;
    logic [1:0]         wave_a_q, wave_a_d;
    logic [1:0]         wave_s_q, wave_s_d;
    logic [7:0]         amp_a_q, amp_a_d;
    logic [7:0]         amp_s_q, amp_s_d;
    logic               pending_q, pending_d;

    // Stage 1: phase and its tags
    logic [PHASE_W-1:0] ph_q, ph_d;
    logic [1:0]         wave1_q, wave1_d;
    logic [7:0]         amp1_q, amp1_d;
    logic               en1_q, en1_d;
    logic               wrap1_q, wrap1_d;

    // Stage 2: raw waveform sample and its tags
    logic [7:0]         w2_q, w2_d;
    logic [7:0]         amp2_q, amp2_d;
    logic               en2_q, en2_d;
    logic               sync2_q, sync2_d;

    // Stage 3: scaled output
    logic [7:0]         data_q, data_d;
    logic               sync_q, sync_d;

    logic               accept;
    logic               apply;
    logic               accumulate;
    logic               wrap;
    logic [PHASE_W:0]   sum;

    logic [7:0]         p;
    logic [6:0]         sine_idx;
    logic [6:0]         sine_mag;

    logic signed [8:0]  dev;
    logic [8:0]         gain;
    logic [18:0]        prod;

    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] v;
        case (k)
            7'd0:    v = 7'd0;
            7'd1:    v = 7'd3;
            7'd2:    v = 7'd6;
            7'd3:    v = 7'd9;
            7'd4:    v = 7'd12;
            7'd5:    v = 7'd16;
            7'd6:    v = 7'd19;
            7'd7:    v = 7'd22;
            7'd8:    v = 7'd25;
            7'd9:    v = 7'd28;
            7'd10:   v = 7'd31;
            7'd11:   v = 7'd34;
            7'd12:   v = 7'd37;
            7'd13:   v = 7'd40;
            7'd14:   v = 7'd43;
            7'd15:   v = 7'd46;
            7'd16:   v = 7'd49;
            7'd17:   v = 7'd51;
            7'd18:   v = 7'd54;
            7'd19:   v = 7'd57;
            7'd20:   v = 7'd60;
            7'd21:   v = 7'd63;
            7'd22:   v = 7'd65;
            7'd23:   v = 7'd68;
            7'd24:   v = 7'd71;
            7'd25:   v = 7'd73;
            7'd26:   v = 7'd76;
            7'd27:   v = 7'd78;
            7'd28:   v = 7'd81;
            7'd29:   v = 7'd83;
            7'd30:   v = 7'd85;
            7'd31:   v = 7'd88;
            7'd32:   v = 7'd90;
            7'd33:   v = 7'd92;
            7'd34:   v = 7'd94;
            7'd35:   v = 7'd96;
            7'd36:   v = 7'd98;
            7'd37:   v = 7'd100;
            7'd38:   v = 7'd102;
            7'd39:   v = 7'd104;
            7'd40:   v = 7'd106;
            7'd41:   v = 7'd107;
            7'd42:   v = 7'd109;
            7'd43:   v = 7'd111;
            7'd44:   v = 7'd112;
            7'd45:   v = 7'd113;
            7'd46:   v = 7'd115;
            7'd47:   v = 7'd116;
            7'd48:   v = 7'd117;
            7'd49:   v = 7'd118;
            7'd50:   v = 7'd120;
            7'd51:   v = 7'd121;
            7'd52:   v = 7'd122;
            7'd53:   v = 7'd122;
            7'd54:   v = 7'd123;
            7'd55:   v = 7'd124;
            7'd56:   v = 7'd125;
            7'd57:   v = 7'd125;
            7'd58:   v = 7'd126;
            7'd59:   v = 7'd126;
            7'd60:   v = 7'd126;
            7'd61:   v = 7'd127;
            7'd62:   v = 7'd127;
            7'd63:   v = 7'd127;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    // Accumulation restarts from a held phase 0 for one cycle after enable rises,
    // so the first enabled sample is always phase 0.
    always_comb begin : cfg_and_phase
        accept     = cfg_valid && !pending_q;
        accumulate = en && en1_q;
        sum        = {1'b0, ph_q} + {1'b0, ftw_a_q};
        wrap       = accumulate && sum[PHASE_W];
        apply      = pending_q && (wrap || !en || (ftw_a_q == '0));

        ftw_s_d  = ftw_s_q;
        wave_s_d = wave_s_q;
        amp_s_d  = amp_s_q;
        if (accept) begin
            ftw_s_d  = cfg_ftw;
            wave_s_d = cfg_wave;
            amp_s_d  = cfg_amp;
        end

        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end

        ftw_a_d  = apply ? ftw_s_q  : ftw_a_q;
        wave_a_d = apply ? wave_s_q : wave_a_q;
        amp_a_d  = apply ? amp_s_q  : amp_a_q;

        // Tags take the post-apply config so the post-wrap sample uses it.
        ph_d    = accumulate ? sum[PHASE_W-1:0] : '0;
        wave1_d = wave_a_d;
        amp1_d  = amp_a_d;
        en1_d   = en;
        wrap1_d = wrap;
    end

    always_comb begin : lookup
        p        = ph_q[PHASE_W-1 -: 8];
        sine_idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        sine_mag = quarter_sine(sine_idx);

        w2_d = MIDSCALE;
        case (wave1_q)
            WAVE_SINE:   w2_d = p[7] ? (MIDSCALE - {1'b0, sine_mag}) : (MIDSCALE + {1'b0, sine_mag});
            WAVE_SQUARE: w2_d = p[7] ? 8'd0 : 8'd255;
            WAVE_TRI:    w2_d = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            WAVE_SAW:    w2_d = p;
            default:     w2_d = MIDSCALE;
        endcase

        amp2_d  = amp1_q;
        en2_d   = en1_q;
        sync2_d = wrap1_q;
    end

    // Full-width product of sign-extended deviation and gain; bits [15:8] are
    // the floored >>>8 result, which always fits in a signed byte.
    always_comb begin : scale
        dev    = $signed({1'b0, w2_q}) - 9'sd128;
        gain   = {1'b0, amp2_q} + 9'd1;
        prod   = {{10{dev[8]}}, dev} * {10'd0, gain};
        data_d = en2_q ? (prod[15:8] + MIDSCALE) : MIDSCALE;
        sync_d = sync2_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_a_q   <= '0;
            ftw_s_q   <= '0;
            wave_a_q  <= WAVE_SINE;
            wave_s_q  <= WAVE_SINE;
            amp_a_q   <= AMP_FULL;
            amp_s_q   <= AMP_FULL;
            pending_q <= 1'b0;
            ph_q      <= '0;
            wave1_q   <= WAVE_SINE;
            amp1_q    <= AMP_FULL;
            en1_q     <= 1'b0;
            wrap1_q   <= 1'b0;
            w2_q      <= MIDSCALE;
            amp2_q    <= AMP_FULL;
            en2_q     <= 1'b0;
            sync2_q   <= 1'b0;
            data_q    <= MIDSCALE;
            sync_q    <= 1'b0;
        end else begin
            ftw_a_q   <= ftw_a_d;
            ftw_s_q   <= ftw_s_d;
            wave_a_q  <= wave_a_d;
            wave_s_q  <= wave_s_d;
            amp_a_q   <= amp_a_d;
            amp_s_q   <= amp_s_d;
            pending_q <= pending_d;
            ph_q      <= ph_d;
            wave1_q   <= wave1_d;
            amp1_q    <= amp1_d;
            en1_q     <= en1_d;
            wrap1_q   <= wrap1_d;
            w2_q      <= w2_d;
            amp2_q    <= amp2_d;
            en2_q     <= en2_d;
            sync2_q   <= sync2_d;
            data_q    <= data_d;
            sync_q    <= sync_d;
        end
    end

    assign cfg_ready = !pending_q;
    assign data_out  = data_q;
    assign sync_out  = sync_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dds_wave_gen : directed self-checking bench for dds_wave_gen           |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_dds_wave_gen;

    localparam int PHASE_W = 32;

    logic               sys_clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_ftw;
    logic [1:0]         cfg_wave;
    logic [7:0]         cfg_amp;
    logic [7:0]         data_out;
    logic               sync_out;

    int errors = 0;
    int checks = 0;
    bit found;

    dds_wave_gen #(.PHASE_W(PHASE_W)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_wave  (cfg_wave),
        .cfg_amp   (cfg_amp),
        .data_out  (data_out),
        .sync_out  (sync_out)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one configuration for a single edge (cfg_ready is high beforehand).
    task automatic send_cfg(input logic [31:0] ftw, input logic [1:0] wave, input logic [7:0] amp);
        cfg_valid = 1'b1;
        cfg_ftw   = ftw;
        cfg_wave  = wave;
        cfg_amp   = amp;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_sync(input string tag);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (sync_out === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ftw   = '0;
        cfg_wave  = 2'd0;
        cfg_amp   = 8'd0;

        // Reset state
        tick(5);
        check("rst_data", {24'd0, data_out}, 128);
        check("rst_sync", {31'd0, sync_out}, 0);
        check("rst_ready", {31'd0, cfg_ready}, 1);
        rst_n = 1'b1;
        en    = 1'b1;
        tick(4);
        check("idle_en_data", {24'd0, data_out}, 128);
        check("idle_en_sync", {31'd0, sync_out}, 0);

        // Sawtooth, applied immediately because ftw_a is 0
        send_cfg(32'h0100_0000, 2'd3, 8'd255);
        check("saw_ready_low", {31'd0, cfg_ready}, 0);
        tick();
        check("saw_ready_high", {31'd0, cfg_ready}, 1);
        tick(2);
        check("saw_first", {24'd0, data_out}, 0);
        check("saw_first_sync", {31'd0, sync_out}, 0);
        for (int k = 1; k < 256; k++) begin
            tick();
            check("saw_step", {24'd0, data_out}, k);
            check("saw_step_sync", {31'd0, sync_out}, 0);
        end
        tick();
        check("saw_wrap", {24'd0, data_out}, 0);
        check("saw_wrap_sync", {31'd0, sync_out}, 1);
        tick();
        check("saw_after_wrap", {24'd0, data_out}, 1);
        check("saw_after_wrap_sync", {31'd0, sync_out}, 0);

        // Deferred update: doubled ftw offered mid-period
        tick(99);
        check("defer_pos", {24'd0, data_out}, 100);
        send_cfg(32'h0200_0000, 2'd3, 8'd255);
        check("defer_accept_data", {24'd0, data_out}, 101);
        check("defer_ready_low", {31'd0, cfg_ready}, 0);
        for (int k = 102; k < 256; k++) begin
            tick();
            check("defer_saw", {24'd0, data_out}, k);
            if (k == 253) check("defer_ready_prewrap", {31'd0, cfg_ready}, 0);
            if (k == 254) check("defer_ready_postwrap", {31'd0, cfg_ready}, 1);
        end
        tick();
        check("defer_wrap", {24'd0, data_out}, 0);
        check("defer_wrap_sync", {31'd0, sync_out}, 1);
        tick();
        check("defer_step2a", {24'd0, data_out}, 2);
        tick();
        check("defer_step2b", {24'd0, data_out}, 4);

        // Sine at ftw = 2^26: period 64 cycles, quarter points every 16
        send_cfg(32'h0400_0000, 2'd0, 8'd255);
        wait_sync("sine_sync_seen");
        check("sine_p0", {24'd0, data_out}, 128);
        tick();
        check("sine_sync_pulse", {31'd0, sync_out}, 0);
        tick(15);
        check("sine_p64", {24'd0, data_out}, 255);
        tick(16);
        check("sine_p128", {24'd0, data_out}, 128);
        tick(16);
        check("sine_p192", {24'd0, data_out}, 1);
        tick(16);
        check("sine_period", {24'd0, data_out}, 128);
        check("sine_period_sync", {31'd0, sync_out}, 1);

        // Square at half amplitude: 191 / 64, 128 cycles each
        send_cfg(32'h0100_0000, 2'd1, 8'd127);
        wait_sync("sq_sync_seen");
        check("sq_high_first", {24'd0, data_out}, 191);
        tick(127);
        check("sq_high_last", {24'd0, data_out}, 191);
        tick();
        check("sq_low_first", {24'd0, data_out}, 64);
        tick(127);
        check("sq_low_last", {24'd0, data_out}, 64);
        tick();
        check("sq_period", {24'd0, data_out}, 191);
        check("sq_period_sync", {31'd0, sync_out}, 1);

        // Enable drop with a pending configuration
        tick(10);
        send_cfg(32'h0100_0000, 2'd3, 8'd255);
        check("endrop_ready_low", {31'd0, cfg_ready}, 0);
        en = 1'b0;
        tick();
        check("endrop_applied", {31'd0, cfg_ready}, 1);
        tick(2);
        check("endrop_mid", {24'd0, data_out}, 128);
        tick(5);
        check("endrop_hold", {24'd0, data_out}, 128);
        en = 1'b1;
        tick(3);
        check("enrise_p0", {24'd0, data_out}, 0);
        tick();
        check("enrise_p1", {24'd0, data_out}, 1);
        tick();
        check("enrise_p2", {24'd0, data_out}, 2);

        // Reset while a configuration is pending
        tick(20);
        send_cfg(32'h0200_0000, 2'd1, 8'd255);
        check("abort_ready_low", {31'd0, cfg_ready}, 0);
        rst_n = 1'b0;
        #1;
        check("abort_async_data", {24'd0, data_out}, 128);
        check("abort_async_sync", {31'd0, sync_out}, 0);
        check("abort_async_ready", {31'd0, cfg_ready}, 1);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_discarded", {24'd0, data_out}, 128);
        end
        check("abort_ready_final", {31'd0, cfg_ready}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
